// File: rtl/io_timer_if.sv
// Bus-side interface for io_timer: address, write data, strobes and read data.
// The CPU drives the master side; the timer sits on the slave side.
interface io_timer_if;
  logic [15:0] address;
  logic [7:0]  din;
  logic        write_en;
  logic        read_en;
  logic [7:0]  dout;

  modport master (output address, output din, output write_en, output read_en, input dout);
  modport slave  (input address, input din, input write_en, input read_en, output dout);
endinterface

// File: rtl/io_timer.sv
// io_timer: memory-mapped 16-bit prescaled timer/counter on the CPU IO page.
// Register window of 8 bytes at BASE_ADDR; 16-bit registers are accessed
// atomically through an 8-bit TEMP latch. The level irq holds until irq_clr_i
// or a W1C write to STATUS.MF.
// Optional build macro IO_TIMER_PWM_EN adds a PWM output with polarity bit CTRL[7];
// without it pwm_out_o is tied low and CTRL[7] is read-only zero.
module io_timer #(
  parameter logic [15:0] BASE_ADDR = 16'h1010
) (
  input  logic        clk,
  input  logic        rst,
  io_timer_if.slave   bus,
  input  logic        irq_clr_i,
  output logic        irq_o,
  output logic        pwm_out_o
);

`ifdef IO_TIMER_PWM_EN
  localparam logic [7:0] CTRL_MASK = 8'hF7;
`else
  localparam logic [7:0] CTRL_MASK = 8'h77;
`endif

  logic        sel, wr, rd;
  logic [2:0]  off;
  logic        en, ctc, ie;
  logic [2:0]  ps;
  logic [7:0]  pre_mask;
  logic        tick;
  logic        cnt_commit;
  logic        mf_set, ovf_set, mf_clr, ovf_clr;

  logic [7:0]  ctrl_q, ctrl_d;
  logic        mf_q, mf_d, ovf_q, ovf_d;
  logic [15:0] cnt_q, cnt_d, cmp_q, cmp_d;
  logic [7:0]  temp_q, temp_d, pre_q, pre_d, dout_q, dout_d;
  logic        irq_q, irq_d;

  assign sel = (bus.address[15:3] == BASE_ADDR[15:3]);
  assign wr  = bus.write_en & sel;
  assign rd  = bus.read_en & sel;
  assign off = bus.address[2:0];

  assign en  = ctrl_q[0];
  assign ctc = ctrl_q[1];
  assign ie  = ctrl_q[2];
  assign ps  = ctrl_q[6:4];

  // Tick fires when the low PS bits of the prescaler are all ones (every cycle for PS=0).
  assign pre_mask   = (8'd1 << ps) - 8'd1;
  assign tick       = en & ((pre_q & pre_mask) == pre_mask);
  assign cnt_commit = wr & (off == 3'd2);

  // Next-state computation for all registers: bus decode, counting, flags, read mux.
  always_comb begin
    ctrl_d  = ctrl_q;
    cnt_d   = cnt_q;
    cmp_d   = cmp_q;
    temp_d  = temp_q;
    pre_d   = en ? (pre_q + 8'd1) : 8'd0;
    mf_set  = 1'b0;
    ovf_set = 1'b0;
    mf_clr  = irq_clr_i | (wr & (off == 3'd1) & bus.din[0]);
    ovf_clr = wr & (off == 3'd1) & bus.din[1];
    dout_d  = 8'd0;

    // Counting comes first so a same-cycle CNT_L commit overrides it below.
    if (tick && !cnt_commit) begin
      if (cnt_q == cmp_q) begin
        mf_set = 1'b1;
        cnt_d  = ctc ? 16'd0 : (cnt_q + 16'd1);
      end else if (cnt_q == 16'hFFFF) begin
        ovf_set = 1'b1;
        cnt_d   = 16'd0;
      end else begin
        cnt_d = cnt_q + 16'd1;
      end
    end

    if (wr) begin
      case (off)
        3'd0:    ctrl_d = bus.din & CTRL_MASK;
        3'd2:    cnt_d  = {temp_q, bus.din};
        3'd3:    temp_d = bus.din;
        3'd4:    cmp_d  = {temp_q, bus.din};
        3'd5:    temp_d = bus.din;
        default: ;
      endcase
    end

    // Reading CNT_L snapshots the high byte so a following CNT_H read is coherent.
    if (rd && (off == 3'd2)) begin
      temp_d = cnt_q[15:8];
    end

    if (rd) begin
      case (off)
        3'd0:    dout_d = ctrl_q;
        3'd1:    dout_d = {6'd0, ovf_q, mf_q};
        3'd2:    dout_d = cnt_q[7:0];
        3'd3:    dout_d = temp_q;
        3'd4:    dout_d = cmp_q[7:0];
        3'd5:    dout_d = cmp_q[15:8];
        default: dout_d = 8'd0;
      endcase
    end

    // Hardware set wins over any clear in the same cycle.
    mf_d  = mf_set  | (mf_q  & ~mf_clr);
    ovf_d = ovf_set | (ovf_q & ~ovf_clr);
    irq_d = mf_q & ie;
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q <= 8'd0;
      mf_q   <= 1'b0;
      ovf_q  <= 1'b0;
      cnt_q  <= 16'd0;
      cmp_q  <= 16'hFFFF;
      temp_q <= 8'd0;
      pre_q  <= 8'd0;
      dout_q <= 8'd0;
      irq_q  <= 1'b0;
    end else begin
      ctrl_q <= ctrl_d;
      mf_q   <= mf_d;
      ovf_q  <= ovf_d;
      cnt_q  <= cnt_d;
      cmp_q  <= cmp_d;
      temp_q <= temp_d;
      pre_q  <= pre_d;
      dout_q <= dout_d;
      irq_q  <= irq_d;
    end
  end

  assign bus.dout = dout_q;
  assign irq_o    = irq_q;

`ifdef IO_TIMER_PWM_EN
  logic pwm_q, pwm_d;

  // PWM is high while the count is below compare; CTRL[7] inverts it.
  always_comb begin
    pwm_d = ctrl_q[7] ^ (en & (cnt_q < cmp_q));
  end

  // PWM output flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pwm_q <= 1'b0;
    else     pwm_q <= pwm_d;
  end

  assign pwm_out_o = pwm_q;
`else
  assign pwm_out_o = 1'b0;
`endif

endmodule

// File: doc/io_timer.md
# io_timer

Memory-mapped 16-bit timer/counter that sits as a responder on the CPU data-memory/IO bus inside the 0x10xx IO page. The CPU reaches this page through its immediate-address IO path. The block decodes bus reads and writes to an 8-byte register window and counts prescaled clock ticks against a compare value. It raises a level interrupt request that stays asserted until the CPU pulses the matching interrupt-clear line.

## Interface
- BASE_ADDR, 16'h1010, base of the 8-byte register window; bits [2:0] are ignored.
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- address  input  16  bus address from the CPU.
- din  input  8  bus write data.
- write_en  input  1  bus write strobe, one cycle per write.
- read_en  input  1  bus read strobe, one cycle per read.
- dout  output  8  registered read data; 0 when not addressed, so it can be OR-combined with other responders.
- irq  output  1  interrupt request; connects to a CPU interrupt_N input.
- irq_clr  input  1  single-cycle clear pulse; connects to the CPU interrupt_N_clr output.
- pwm_out  output  1  PWM output (see Configuration).

## Operation
- Select: sel = (address[15:3] == BASE_ADDR[15:3]). Write and read strobes are ignored when sel=0.
- Register map (offset = address[2:0]):
  - 0 CTRL (R/W): [0] EN, [1] CTC (clear on match), [2] IE, [6:4] PS, [7] reserved (reads 0).
  - 1 STATUS: [0] MF (match flag), [1] OVF (overflow flag); write-1-to-clear.
  - 2 CNT_L, 3 CNT_H: counter bytes.
  - 4 CMP_L, 5 CMP_H: compare bytes.
  - 6, 7: read 0; writes are ignored.
- 16-bit atomic access uses an 8-bit TEMP register:
  - Writing CNT_H or CMP_H stores din in TEMP only.
  - Writing CNT_L commits {TEMP, din} to CNT. Writing CMP_L commits {TEMP, din} to CMP.
  - Reading CNT_L returns CNT[7:0] and copies CNT[15:8] to TEMP in the same edge.
  - Reading CNT_H returns TEMP. CMP_H reads return CMP[15:8] directly.
- Prescaler:
  - 8-bit free-running counter `pre`; it holds at 0 while EN=0.
  - tick = EN & (pre[PS-1:0] all ones); for PS=0, tick = EN every cycle. Divide ratio is 2^PS.
- On a tick, with old count c:
  - If c==CMP: MF←1. If CTC=1, CNT←0; otherwise CNT←c+1.
  - Else if c==16'hFFFF: CNT←0, OVF←1.
  - Else: CNT←c+1.
  - All arithmetic is modulo 2^16.
- Priorities:
  - A bus commit to CNT in the same cycle as a tick wins: CNT takes the written value, and the match/overflow check for that tick is skipped.
  - A hardware set of MF or OVF wins over a simultaneous W1C write or irq_clr.
- irq = MF & IE, registered (it is a flop output).
- irq_clr=1 clears MF, which drops irq on the next cycle.

## Timing
- Reset values: CTRL=0, STATUS=0, CNT=0, CMP=16'hFFFF, TEMP=0, pre=0, dout=0, irq=0, pwm_out=0.
- Writes take effect at the rising edge on which write_en=1.
- Read latency is 1 cycle:
  - dout ← selected register at the edge where read_en & sel.
  - Otherwise dout ← 0 at every edge.
  - A read and a write in the same cycle: dout returns the pre-write value.
- Flag-to-irq latency: MF sets at the tick edge; irq rises 1 cycle later.
- Clear latency: irq falls 1 cycle after the irq_clr edge, or after a STATUS write of 1 to bit 0.
- Clearing EN stops counting on the next edge; CNT holds its value and pre returns to 0.
- Reset asserted mid-operation immediately forces all reset values, including during a pending irq.

## Configuration
- IO_TIMER_PWM_EN defined:
  - pwm_out is a flop with next value EN & (CNT < CMP).
  - CTRL[7] becomes R/W bit POL; when POL=1 the PWM output is inverted.
- IO_TIMER_PWM_EN undefined:
  - pwm_out is constant 0.
  - CTRL[7] reads 0 and ignores writes.
  - No comparator beyond the equality check is built.

## Test plan
- Reset, then read every offset 0–7: dout = 00,00,00,00,FF,FF,00,00 one cycle after each read_en; irq=0.
- Write CMP_H=00, CMP_L=04, CTRL=0x05 (EN, IE, PS=0) → CNT counts 0..4. MF sets at the edge after CNT==4, irq=1 one cycle later, and CNT continues to 5. Pulse irq_clr → irq=0 the next cycle.
- Set CTRL=0x07 with CMP=0x0003 → CNT sequence is 0,1,2,3,0,1…; MF sets every 4 ticks.
- Set CTRL=0x31 (PS=3) with CNT=0xFFFE → increments every 8 cycles. On 0xFFFF→0, OVF=1 and irq stays 0 (IE=0). Write STATUS=0x02 → OVF=0.
- Atomic read with the counter running: read CNT_L then CNT_H → the returned 16-bit value equals CNT at the CNT_L read. Write CNT_H=0x12 then CNT_L=0x34 during ticks → CNT=0x1234 on the commit edge.
- Drive irq_clr in the same cycle MF is set by a match → MF stays 1 and irq remains 1. Assert rst mid-count → all outputs go to 0 immediately. With IO_TIMER_PWM_EN defined and CMP=2, pwm_out is high for 2 of every 3 counts in CTC mode.
